// File: rtl/regbank_write_arbiter_if.sv
// Writeback-side bus of the register-bank write arbiter.
// Two requesters, decode issue port, bank write port, scoreboard.
interface regbank_write_arbiter_if #(
  parameter int NREG = 16,
  parameter int AW   = 4,
  parameter int DW   = 32
);
  logic          req0_valid;
  logic [AW-1:0] req0_reg;
  logic [DW-1:0] req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [AW-1:0] req1_reg;
  logic [DW-1:0] req1_data;
  logic          req1_ready;
  logic          issue_valid;
  logic [AW-1:0] issue_reg;
  logic          wr_en;
  logic [AW-1:0] wr_reg;
  logic [DW-1:0] wr_data;
  logic [NREG-1:0] busy_vec;
  logic          last_grant;

  modport master (
    output req0_valid, req0_reg, req0_data,
    output req1_valid, req1_reg, req1_data,
    output issue_valid, issue_reg,
    input  req0_ready, req1_ready,
    input  wr_en, wr_reg, wr_data,
    input  busy_vec, last_grant
  );

  modport slave (
    input  req0_valid, req0_reg, req0_data,
    input  req1_valid, req1_reg, req1_data,
    input  issue_valid, issue_reg,
    output req0_ready, req1_ready,
    output wr_en, wr_reg, wr_data,
    output busy_vec, last_grant
  );
endinterface

// File: rtl/regbank_write_arbiter.sv
// Round-robin arbiter for the register-bank write port.
// Also tracks pending writes per register for RAW stalls.
module regbank_write_arbiter #(
  parameter int NREG = 16,
  parameter int AW   = 4,
  parameter int DW   = 32
) (
  input logic clk,
  input logic rst,
  regbank_write_arbiter_if.slave bus
);

  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } pri_e;

  pri_e            pri_q, pri_d;
  logic            lg_q, lg_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_reg_q, wr_reg_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            gnt0, gnt1;

  // Grant: lone requester wins, ties go to the pointer.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (bus.req0_valid && bus.req1_valid) begin
        gnt0 = (pri_q == PRI0);
        gnt1 = (pri_q == PRI1);
      end else begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid;
      end
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;

  // Pointer/last-grant update and write-port capture; R0 writes drop.
  always_comb begin
    pri_d     = pri_q;
    lg_d      = lg_q;
    wr_en_d   = 1'b0;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    unique case (1'b1)
      gnt0: begin
        pri_d = PRI1;
        lg_d  = 1'b0;
        if (bus.req0_reg != '0) begin
          wr_en_d   = 1'b1;
          wr_reg_d  = bus.req0_reg;
          wr_data_d = bus.req0_data;
        end
      end
      gnt1: begin
        pri_d = PRI0;
        lg_d  = 1'b1;
        if (bus.req1_reg != '0) begin
          wr_en_d   = 1'b1;
          wr_reg_d  = bus.req1_reg;
          wr_data_d = bus.req1_data;
        end
      end
      default: ;
    endcase
  end

  // Scoreboard: commit clears, issue sets, set applied last so it wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_q) begin
      busy_d[wr_reg_q] = 1'b0;
    end
    if (bus.issue_valid && (bus.issue_reg != '0)) begin
      busy_d[bus.issue_reg] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pri_q     <= PRI0;
      lg_q      <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
    end else begin
      pri_q     <= pri_d;
      lg_q      <= lg_d;
      wr_en_q   <= wr_en_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_reg     = wr_reg_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.busy_vec   = busy_q;
  assign bus.last_grant = lg_q;

  // Handshake invariants: one grant at most, never without valid.
  always_ff @(posedge clk) begin
    assert (!(gnt0 && gnt1));
    assert (!gnt0 || bus.req0_valid);
    assert (!gnt1 || bus.req1_valid);
    assert (!busy_q[0]);
  end

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed bench for regbank_write_arbiter.
// Vector table plus hand sequences for scoreboard and reset.
module tb_regbank_write_arbiter;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  regbank_write_arbiter_if #(.NREG(16), .AW(4), .DW(32)) bus ();

  regbank_write_arbiter #(.NREG(16), .AW(4), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        v0;
    logic [3:0]  r0;
    logic [31:0] d0;
    logic        v1;
    logic [3:0]  r1;
    logic [31:0] d1;
    logic        iv;
    logic [3:0]  ir;
    logic        x0;
    logic        x1;
    logic        xen;
    logic        cw;
    logic [3:0]  xreg;
    logic [31:0] xdat;
    logic [15:0] xbusy;
    logic        xlg;
  } vec_t;

  vec_t vt[17];

  function automatic vec_t mk(
    input logic r, input logic v0, input logic [3:0] r0,
    input logic [31:0] d0, input logic v1, input logic [3:0] r1,
    input logic [31:0] d1, input logic iv, input logic [3:0] ir,
    input logic x0, input logic x1, input logic xen, input logic cw,
    input logic [3:0] xreg, input logic [31:0] xdat,
    input logic [15:0] xbusy, input logic xlg);
    vec_t t;
    t.rst = r;   t.v0 = v0;   t.r0 = r0;   t.d0 = d0;
    t.v1 = v1;   t.r1 = r1;   t.d1 = d1;
    t.iv = iv;   t.ir = ir;
    t.x0 = x0;   t.x1 = x1;   t.xen = xen; t.cw = cw;
    t.xreg = xreg; t.xdat = xdat; t.xbusy = xbusy; t.xlg = xlg;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(
    input logic r, input logic v0, input logic [3:0] r0,
    input logic [31:0] d0, input logic v1, input logic [3:0] r1,
    input logic [31:0] d1, input logic iv, input logic [3:0] ir);
    @(posedge clk);
    #1;
    rst             = r;
    bus.req0_valid  = v0;
    bus.req0_reg    = r0;
    bus.req0_data   = d0;
    bus.req1_valid  = v1;
    bus.req1_reg    = r1;
    bus.req1_data   = d1;
    bus.issue_valid = iv;
    bus.issue_reg   = ir;
    @(negedge clk);
  endtask

  task automatic idle(input logic r);
    drive(r, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.req0_valid = 0; bus.req0_reg = 0; bus.req0_data = 0;
    bus.req1_valid = 0; bus.req1_reg = 0; bus.req1_data = 0;
    bus.issue_valid = 0; bus.issue_reg = 0;

    vt[0]  = mk(1,0,0,0,0,0,0,0,0, 0,0,0,1,0,0,0,0);
    vt[1]  = mk(0,1,5,'hAA,0,0,0,0,0, 1,0,0,0,0,0,0,0);
    vt[2]  = mk(0,0,0,0,0,0,0,0,0, 0,0,1,1,5,'hAA,0,0);
    vt[3]  = mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0);
    vt[4]  = mk(1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0);
    vt[5]  = mk(0,1,3,'h30,1,4,'h40,0,0, 1,0,0,0,0,0,0,0);
    vt[6]  = mk(0,1,3,'h30,1,4,'h40,0,0, 0,1,1,1,3,'h30,0,0);
    vt[7]  = mk(0,1,3,'h30,1,4,'h40,0,0, 1,0,1,1,4,'h40,0,1);
    vt[8]  = mk(0,1,3,'h30,1,4,'h40,0,0, 0,1,1,1,3,'h30,0,0);
    vt[9]  = mk(0,1,3,'h30,1,4,'h40,0,0, 1,0,1,1,4,'h40,0,1);
    vt[10] = mk(0,1,3,'h30,1,4,'h40,0,0, 0,1,1,1,3,'h30,0,0);
    vt[11] = mk(0,0,0,0,0,0,0,0,0, 0,0,1,1,4,'h40,0,1);
    vt[12] = mk(0,1,0,'h55,0,0,0,1,0, 1,0,0,0,0,0,0,1);
    vt[13] = mk(0,1,2,'h22,1,6,'h66,0,0, 0,1,0,0,0,0,0,0);
    vt[14] = mk(0,1,2,'h22,0,0,0,0,0, 1,0,1,1,6,'h66,0,1);
    vt[15] = mk(0,0,0,0,0,0,0,0,0, 0,0,1,1,2,'h22,0,0);
    vt[16] = mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0);

    repeat (2) @(posedge clk);

    for (int i = 0; i < 17; i++) begin
      drive(vt[i].rst, vt[i].v0, vt[i].r0, vt[i].d0, vt[i].v1,
            vt[i].r1, vt[i].d1, vt[i].iv, vt[i].ir);
      chk($sformatf("v%0d rdy0", i), bus.req0_ready, vt[i].x0);
      chk($sformatf("v%0d rdy1", i), bus.req1_ready, vt[i].x1);
      chk($sformatf("v%0d wr_en", i), bus.wr_en, vt[i].xen);
      if (vt[i].cw) begin
        chk($sformatf("v%0d wr_reg", i), bus.wr_reg, vt[i].xreg);
        chk($sformatf("v%0d wr_data", i), bus.wr_data, vt[i].xdat);
      end
      chk($sformatf("v%0d busy", i), bus.busy_vec, vt[i].xbusy);
      chk($sformatf("v%0d lg", i), bus.last_grant, vt[i].xlg);
    end

    // Scoreboard lifetime: issue R7, load writes R7 three cycles later
    drive(0, 0,0,0, 0,0,0, 1,7);
    chk("sbA N busy", bus.busy_vec, 16'h0000);
    idle(0);
    chk("sbA N+1 busy", bus.busy_vec, 16'h0080);
    idle(0);
    chk("sbA N+2 busy", bus.busy_vec, 16'h0080);
    drive(0, 0,0,0, 1,7,'h77, 0,0);
    chk("sbA N+3 rdy1", bus.req1_ready, 1);
    chk("sbA N+3 busy", bus.busy_vec, 16'h0080);
    idle(0);
    chk("sbA N+4 wr_en", bus.wr_en, 1);
    chk("sbA N+4 wr_reg", bus.wr_reg, 7);
    chk("sbA N+4 wr_data", bus.wr_data, 32'h77);
    chk("sbA N+4 busy", bus.busy_vec, 16'h0080);
    idle(0);
    chk("sbA N+5 busy", bus.busy_vec, 16'h0000);

    // Set and clear on the same bit, then on different bits
    drive(0, 0,0,0, 0,0,0, 1,9);
    chk("sbB M busy", bus.busy_vec, 16'h0000);
    drive(0, 1,9,'h99, 0,0,0, 0,0);
    chk("sbB M+1 rdy0", bus.req0_ready, 1);
    chk("sbB M+1 busy", bus.busy_vec, 16'h0200);
    drive(0, 0,0,0, 0,0,0, 1,9);
    chk("sbB M+2 wr_en", bus.wr_en, 1);
    chk("sbB M+2 wr_reg", bus.wr_reg, 9);
    drive(0, 0,0,0, 1,9,'h9A, 1,3);
    chk("sbB M+3 busy", bus.busy_vec, 16'h0200);
    chk("sbB M+3 rdy1", bus.req1_ready, 1);
    drive(0, 0,0,0, 0,0,0, 1,2);
    chk("sbB M+4 wr_reg", bus.wr_reg, 9);
    chk("sbB M+4 busy", bus.busy_vec, 16'h0208);
    idle(0);
    chk("sbB M+5 busy", bus.busy_vec, 16'h000C);

    // Reset mid-operation with pending busy bits and req1 waiting
    idle(1);
    for (int k = 4; k < 8; k++) begin
      drive(0, 0,0,0, 0,0,0, 1,4'(k));
    end
    drive(0, 0,0,0, 1,10,'hA0, 0,0);
    chk("rstC pre busy", bus.busy_vec, 16'h00F0);
    chk("rstC pre rdy1", bus.req1_ready, 1);
    drive(1, 0,0,0, 1,8,'h88, 0,0);
    chk("rstC R rdy1", bus.req1_ready, 0);
    chk("rstC R wr_en", bus.wr_en, 1);
    chk("rstC R wr_reg", bus.wr_reg, 10);
    chk("rstC R wr_data", bus.wr_data, 32'hA0);
    chk("rstC R lg", bus.last_grant, 1);
    drive(1, 0,0,0, 1,8,'h88, 0,0);
    chk("rstC R+1 busy", bus.busy_vec, 16'h0000);
    chk("rstC R+1 wr_en", bus.wr_en, 0);
    chk("rstC R+1 lg", bus.last_grant, 0);
    chk("rstC R+1 rdy1", bus.req1_ready, 0);
    drive(0, 0,0,0, 1,8,'h88, 0,0);
    chk("rstC R+2 rdy1", bus.req1_ready, 1);
    chk("rstC R+2 rdy0", bus.req0_ready, 0);
    idle(0);
    chk("rstC R+3 wr_en", bus.wr_en, 1);
    chk("rstC R+3 wr_reg", bus.wr_reg, 8);
    chk("rstC R+3 wr_data", bus.wr_data, 32'h88);
    chk("rstC R+3 busy", bus.busy_vec, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
